// File: rtl/lvt_write_scheduler.sv
// Two-channel write scheduler for lvt_bram: per-channel FIFOs, registered write ports and
// same-address arbitration. Define LVT_WRITE_COALESCE_EN to merge conflicting heads instead.
module lvt_write_scheduler #(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  req0_valid_i,
    output logic                  req0_ready_o,
    input  logic [ADDR_WIDTH-1:0] req0_addr_i,
    input  logic [DATA_WIDTH-1:0] req0_data_i,
    input  logic                  req1_valid_i,
    output logic                  req1_ready_o,
    input  logic [ADDR_WIDTH-1:0] req1_addr_i,
    input  logic [DATA_WIDTH-1:0] req1_data_i,
    input  logic                  hold_i,
    output logic                  wr0_en_o,
    output logic [ADDR_WIDTH-1:0] wr0_addr_o,
    output logic [DATA_WIDTH-1:0] wr0_data_o,
    output logic                  wr1_en_o,
    output logic [ADDR_WIDTH-1:0] wr1_addr_o,
    output logic [DATA_WIDTH-1:0] wr1_data_o,
    output logic [15:0]           conflict_cnt_o,
    output logic                  idle_o
);

    localparam int unsigned PtrW   = $clog2(FIFO_DEPTH);
    localparam int unsigned EntryW = ADDR_WIDTH + DATA_WIDTH;
    localparam logic [PtrW:0] PtrOne = 1;

    typedef enum logic [0:0] {StIssue, StDefer} state_e;

    state_e state_q, state_d;

    logic [EntryW-1:0] mem0_q [FIFO_DEPTH];
    logic [EntryW-1:0] mem1_q [FIFO_DEPTH];
    logic [PtrW:0]     wptr0_q, rptr0_q, wptr1_q, rptr1_q;

    logic empty0, empty1, full0, full1;
    logic push0, push1, pop0, pop1;
    logic iss0, iss1, conflict, cnt_inc;

    logic [EntryW-1:0]     head0, head1;
    logic [ADDR_WIDTH-1:0] head0_addr, head1_addr;
    logic [DATA_WIDTH-1:0] head0_data, head1_data;

    logic                  wr0_en_q, wr1_en_q;
    logic [ADDR_WIDTH-1:0] wr0_addr_q, wr0_addr_d, wr1_addr_q, wr1_addr_d;
    logic [DATA_WIDTH-1:0] wr0_data_q, wr0_data_d, wr1_data_q, wr1_data_d;
    logic [15:0]           cnt_q, cnt_d;

    // Full when the wrap bits differ and the index bits match.
    assign empty0 = (wptr0_q == rptr0_q);
    assign empty1 = (wptr1_q == rptr1_q);
    assign full0  = (wptr0_q[PtrW] != rptr0_q[PtrW]) &&
                    (wptr0_q[PtrW-1:0] == rptr0_q[PtrW-1:0]);
    assign full1  = (wptr1_q[PtrW] != rptr1_q[PtrW]) &&
                    (wptr1_q[PtrW-1:0] == rptr1_q[PtrW-1:0]);

    assign req0_ready_o = !full0;
    assign req1_ready_o = !full1;
    assign push0        = req0_valid_i && !full0;
    assign push1        = req1_valid_i && !full1;

    assign head0      = mem0_q[rptr0_q[PtrW-1:0]];
    assign head1      = mem1_q[rptr1_q[PtrW-1:0]];
    assign head0_addr = head0[EntryW-1 -: ADDR_WIDTH];
    assign head1_addr = head1[EntryW-1 -: ADDR_WIDTH];
    assign head0_data = head0[DATA_WIDTH-1:0];
    assign head1_data = head1[DATA_WIDTH-1:0];

    assign conflict = !empty0 && !empty1 && (head0_addr == head1_addr);

    always_ff @(posedge clk_i) begin
        if (push0) begin
            mem0_q[wptr0_q[PtrW-1:0]] <= {req0_addr_i, req0_data_i};
        end
        if (push1) begin
            mem1_q[wptr1_q[PtrW-1:0]] <= {req1_addr_i, req1_data_i};
        end
    end

    always_comb begin
        pop0    = 1'b0;
        pop1    = 1'b0;
        iss0    = 1'b0;
        iss1    = 1'b0;
        cnt_inc = 1'b0;
        state_d = state_q;
        if (!hold_i) begin
            unique case (state_q)
                StIssue: begin
                    if (conflict) begin
                        cnt_inc = 1'b1;
`ifdef LVT_WRITE_COALESCE_EN
                        // Channel 1 wins the address; the channel 0 write is discarded.
                        pop0    = 1'b1;
                        pop1    = 1'b1;
                        iss1    = 1'b1;
`else
                        pop0    = 1'b1;
                        iss0    = 1'b1;
                        state_d = StDefer;
`endif
                    end else begin
                        pop0 = !empty0;
                        iss0 = !empty0;
                        pop1 = !empty1;
                        iss1 = !empty1;
                    end
                end
                StDefer: begin
                    pop1    = !empty1;
                    iss1    = !empty1;
                    state_d = StIssue;
                end
                default: state_d = StIssue;
            endcase
        end
    end

    always_comb begin
        wr0_addr_d = wr0_addr_q;
        wr0_data_d = wr0_data_q;
        wr1_addr_d = wr1_addr_q;
        wr1_data_d = wr1_data_q;
        if (iss0) begin
            wr0_addr_d = head0_addr;
            wr0_data_d = head0_data;
        end
        if (iss1) begin
            wr1_addr_d = head1_addr;
            wr1_data_d = head1_data;
        end
        cnt_d = cnt_q;
        if (cnt_inc && (cnt_q != 16'hFFFF)) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= StIssue;
            wptr0_q    <= '0;
            rptr0_q    <= '0;
            wptr1_q    <= '0;
            rptr1_q    <= '0;
            wr0_en_q   <= 1'b0;
            wr1_en_q   <= 1'b0;
            wr0_addr_q <= '0;
            wr0_data_q <= '0;
            wr1_addr_q <= '0;
            wr1_data_q <= '0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            if (push0) wptr0_q <= wptr0_q + PtrOne;
            if (pop0)  rptr0_q <= rptr0_q + PtrOne;
            if (push1) wptr1_q <= wptr1_q + PtrOne;
            if (pop1)  rptr1_q <= rptr1_q + PtrOne;
            wr0_en_q   <= iss0;
            wr1_en_q   <= iss1;
            wr0_addr_q <= wr0_addr_d;
            wr0_data_q <= wr0_data_d;
            wr1_addr_q <= wr1_addr_d;
            wr1_data_q <= wr1_data_d;
            cnt_q      <= cnt_d;
        end
    end

    assign wr0_en_o       = wr0_en_q;
    assign wr0_addr_o     = wr0_addr_q;
    assign wr0_data_o     = wr0_data_q;
    assign wr1_en_o       = wr1_en_q;
    assign wr1_addr_o     = wr1_addr_q;
    assign wr1_data_o     = wr1_data_q;
    assign conflict_cnt_o = cnt_q;
    assign idle_o         = empty0 && empty1 && (state_q == StIssue) && !wr0_en_q && !wr1_en_q;

endmodule

// File: tb/tb_lvt_write_scheduler.sv
// Randomized and directed bench for lvt_write_scheduler against a queue-based reference model.
module tb_lvt_write_scheduler;

    localparam int AW    = 8;
    localparam int DW    = 8;
    localparam int DEPTH = 4;

    logic          clk_i = 1'b0;
    logic          rst_ni = 1'b0;
    logic          req0_valid_i = 1'b0, req1_valid_i = 1'b0, hold_i = 1'b0;
    logic [AW-1:0] req0_addr_i = '0, req1_addr_i = '0;
    logic [DW-1:0] req0_data_i = '0, req1_data_i = '0;
    logic          req0_ready_o, req1_ready_o;
    logic          wr0_en_o, wr1_en_o, idle_o;
    logic [AW-1:0] wr0_addr_o, wr1_addr_o;
    logic [DW-1:0] wr0_data_o, wr1_data_o;
    logic [15:0]   conflict_cnt_o;

    lvt_write_scheduler #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .req0_valid_i  (req0_valid_i),
        .req0_ready_o  (req0_ready_o),
        .req0_addr_i   (req0_addr_i),
        .req0_data_i   (req0_data_i),
        .req1_valid_i  (req1_valid_i),
        .req1_ready_o  (req1_ready_o),
        .req1_addr_i   (req1_addr_i),
        .req1_data_i   (req1_data_i),
        .hold_i        (hold_i),
        .wr0_en_o      (wr0_en_o),
        .wr0_addr_o    (wr0_addr_o),
        .wr0_data_o    (wr0_data_o),
        .wr1_en_o      (wr1_en_o),
        .wr1_addr_o    (wr1_addr_o),
        .wr1_data_o    (wr1_data_o),
        .conflict_cnt_o(conflict_cnt_o),
        .idle_o        (idle_o)
    );

    always #5 clk_i = ~clk_i;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: one queue of {addr, data} per channel plus a pending-deferral flag.
    logic [AW+DW-1:0] q0[$];
    logic [AW+DW-1:0] q1[$];
    bit               m_defer;
    int               m_cnt;
    bit               m_acc0, m_acc1;
    logic             exp_en0, exp_en1;
    logic [AW-1:0]    exp_a0, exp_a1;
    logic [DW-1:0]    exp_d0, exp_d1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        q0.delete();
        q1.delete();
        m_defer = 0;
        m_cnt   = 0;
        exp_en0 = 0; exp_en1 = 0;
        exp_a0  = '0; exp_a1 = '0;
        exp_d0  = '0; exp_d1 = '0;
    endtask

    task automatic check_all();
        check_eq("wr0_en", {31'd0, wr0_en_o}, {31'd0, exp_en0});
        check_eq("wr0_addr", {24'd0, wr0_addr_o}, {24'd0, exp_a0});
        check_eq("wr0_data", {24'd0, wr0_data_o}, {24'd0, exp_d0});
        check_eq("wr1_en", {31'd0, wr1_en_o}, {31'd0, exp_en1});
        check_eq("wr1_addr", {24'd0, wr1_addr_o}, {24'd0, exp_a1});
        check_eq("wr1_data", {24'd0, wr1_data_o}, {24'd0, exp_d1});
        check_eq("conflict_cnt", {16'd0, conflict_cnt_o}, m_cnt);
        check_eq("ready0", {31'd0, req0_ready_o}, (q0.size() < DEPTH) ? 1 : 0);
        check_eq("ready1", {31'd0, req1_ready_o}, (q1.size() < DEPTH) ? 1 : 0);
        check_eq("idle", {31'd0, idle_o},
                 (q0.size() == 0 && q1.size() == 0 && !m_defer && !exp_en0 && !exp_en1) ? 1 : 0);
        if (wr0_en_o && wr1_en_o) begin
            check_eq("port_addr_distinct", {31'd0, wr0_addr_o == wr1_addr_o}, 0);
        end
    endtask

    // One clock: apply the model at the rising edge, compare on the falling edge.
    task automatic step();
        logic [AW+DW-1:0] h;
        bit e0, e1;
        @(posedge clk_i);
        m_acc0 = req0_valid_i && (q0.size() < DEPTH);
        m_acc1 = req1_valid_i && (q1.size() < DEPTH);
        e0 = 0;
        e1 = 0;
        if (!hold_i) begin
            if (m_defer) begin
                if (q1.size() > 0) begin
                    h = q1.pop_front(); e1 = 1; exp_a1 = h[AW+DW-1:DW]; exp_d1 = h[DW-1:0];
                end
                m_defer = 0;
            end else if (q0.size() > 0 && q1.size() > 0 && q0[0][AW+DW-1:DW] == q1[0][AW+DW-1:DW]) begin
                if (m_cnt < 65535) m_cnt++;
`ifdef LVT_WRITE_COALESCE_EN
                void'(q0.pop_front());
                h = q1.pop_front(); e1 = 1; exp_a1 = h[AW+DW-1:DW]; exp_d1 = h[DW-1:0];
`else
                h = q0.pop_front(); e0 = 1; exp_a0 = h[AW+DW-1:DW]; exp_d0 = h[DW-1:0];
                m_defer = 1;
`endif
            end else begin
                if (q0.size() > 0) begin
                    h = q0.pop_front(); e0 = 1; exp_a0 = h[AW+DW-1:DW]; exp_d0 = h[DW-1:0];
                end
                if (q1.size() > 0) begin
                    h = q1.pop_front(); e1 = 1; exp_a1 = h[AW+DW-1:DW]; exp_d1 = h[DW-1:0];
                end
            end
        end
        exp_en0 = e0;
        exp_en1 = e1;
        if (m_acc0) q0.push_back({req0_addr_i, req0_data_i});
        if (m_acc1) q1.push_back({req1_addr_i, req1_data_i});
        @(negedge clk_i);
        check_all();
    endtask

    task automatic drive(input logic v0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                         input logic v1, input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                         input logic h);
        req0_valid_i = v0; req0_addr_i = a0; req0_data_i = d0;
        req1_valid_i = v1; req1_addr_i = a1; req1_data_i = d1;
        hold_i       = h;
    endtask

    task automatic idle_steps(input int n);
        drive(0, '0, '0, 0, '0, '0, 0);
        for (int i = 0; i < n; i++) step();
    endtask

    // Asynchronous reset asserted between edges, checked immediately, released on a falling edge.
    task automatic do_reset();
        rst_ni = 1'b0;
        drive(0, '0, '0, 0, '0, '0, 0);
        #1;
        model_reset();
        check_eq("rst_wr0_en", {31'd0, wr0_en_o}, 0);
        check_eq("rst_wr1_en", {31'd0, wr1_en_o}, 0);
        check_eq("rst_wr_addr", {16'd0, wr0_addr_o, wr1_addr_o}, 0);
        check_eq("rst_wr_data", {16'd0, wr0_data_o, wr1_data_o}, 0);
        check_eq("rst_cnt", {16'd0, conflict_cnt_o}, 0);
        check_eq("rst_idle", {31'd0, idle_o}, 1);
        @(negedge clk_i);
        rst_ni = 1'b1;
        #1;
        check_eq("rst_ready0", {31'd0, req0_ready_o}, 1);
        check_eq("rst_ready1", {31'd0, req1_ready_o}, 1);
        @(negedge clk_i);
    endtask

    initial begin
        int idx;
        model_reset();
        repeat (2) @(negedge clk_i);
        do_reset();

        // Single channel-0 write.
        drive(1, 8'd10, 8'd5, 0, '0, '0, 0);
        step();
        drive(0, '0, '0, 0, '0, '0, 0);
        step();
        check_eq("single_en", {31'd0, wr0_en_o}, 1);
        idle_steps(2);

        // Parallel writes to different addresses.
        drive(1, 8'd30, 8'd15, 1, 8'd40, 8'd20, 0);
        step();
        idle_steps(3);

        // Same-address conflict.
        drive(1, 8'd50, 8'd25, 1, 8'd50, 8'd30, 0);
        step();
        idle_steps(4);

        // Conflict with hold raised during the deferred cycle.
        drive(1, 8'd60, 8'd1, 1, 8'd60, 8'd2, 0);
        step();
        idle_steps(1);
        drive(0, '0, '0, 0, '0, '0, 1);
        repeat (3) step();
        idle_steps(3);

        // Backpressure under hold, then drain in order.
        idx = 0;
        for (int c = 0; c < 6; c++) begin
            drive(1, AW'(70 + idx), AW'(idx), 0, '0, '0, 1);
            step();
            if (m_acc0) idx++;
            if (idx == 4) check_eq("bp_ready_low", {31'd0, req0_ready_o}, 0);
        end
        for (int c = 0; c < 10 && idx < 5; c++) begin
            drive(1, AW'(70 + idx), AW'(idx), 0, '0, '0, 0);
            step();
            if (m_acc0) idx++;
        end
        check_eq("bp_all_accepted", idx, 5);
        idle_steps(6);

        // Randomized traffic over a narrow address range to provoke conflicts.
        for (int i = 0; i < 600; i++) begin
            if (i == 300) do_reset();
            drive($urandom_range(0, 1), AW'($urandom_range(0, 3)), DW'($urandom),
                  $urandom_range(0, 1), AW'($urandom_range(0, 3)), DW'($urandom),
                  $urandom_range(0, 4) == 0);
            step();
        end
        idle_steps(8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
